complex_mac_seq: RTL and testbench

COMPLEX_MAC_SEQ -- requirements
Module: complex_mac_seq

---
 rtl/complex_mac_seq.sv | 267 ++++++++++++++++++++++++++
 tb/tb_complex_mac_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/complex_mac_seq.sv
// Sequential complex multiply-accumulate: one shared shift-add W x W signed multiplier
// computes the four partial products of X*Y in turn and folds them into RW-bit results.
module complex_mac_seq #(
    parameter int W     = 8,
    parameter int GUARD = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          accum,
    input  logic                          clear,
    input  logic signed [W-1:0]           x_re,
    input  logic signed [W-1:0]           x_im,
    input  logic signed [W-1:0]           y_re,
    input  logic signed [W-1:0]           y_im,
    output logic                          busy,
    output logic                          done,
    output logic signed [2*W+GUARD-1:0]   res_re,
    output logic signed [2*W+GUARD-1:0]   res_im,
    output logic                          ovf
);

    localparam int RW = 2*W + GUARD;
    localparam int PW = 2*W;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W-1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MUL  = 3'd2,
        ST_ACC  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            accept_s;

    logic [W-1:0]    xr_r, xi_r, yr_r, yi_r;
    logic            accum_r;
    logic [1:0]      k_r;
    logic [1:0]      ld_k_s;
    logic [W-1:0]    op_a_s, op_b_s;

    logic [PW-1:0]   mcand_r;
    logic [W-1:0]    mplier_r;
    logic [PW-1:0]   prod_r;
    logic [CW-1:0]   cnt_r;
    logic [PW-1:0]   partial_s;

    logic [RW-1:0]   res_re_r, res_im_r;
    logic            ovf_r;
    logic            busy_r, done_r;

    logic [RW-1:0]   prod_ext_s;
    logic [RW-1:0]   acc_a_s;
    logic [RW-1:0]   acc_sum_s;
    logic            acc_sub_s;
    logic            acc_ovf_s;

    // Signed overflow of a +/- b given the wrapped result s
    function automatic logic acc_overflow(input logic [RW-1:0] a, input logic [RW-1:0] b,
                                          input logic [RW-1:0] s, input logic sub);
        logic same_sign;
        same_sign = (a[RW-1] == b[RW-1]);
        if (sub) begin
            return !same_sign && (s[RW-1] != a[RW-1]);
        end else begin
            return same_sign && (s[RW-1] != a[RW-1]);
        end
    endfunction

    // Next-state decode and start acceptance
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clear) begin
                    state_nxt_s = ST_IDLE;
                end else if (start) begin
                    state_nxt_s = ST_LOAD;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: state_nxt_s = ST_MUL;
            ST_MUL: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_ACC;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            ST_ACC: begin
                if (k_r == 2'd3) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            ST_DONE: begin
                // The edge that ends DONE can already accept the next request
                if (start && !clear) begin
                    state_nxt_s = ST_LOAD;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand pair feeding the multiplier for the product about to start
    always_comb begin
        ld_k_s = 2'd0;
        if (state_r == ST_ACC) begin
            ld_k_s = k_r + 2'd1;
        end else begin
            ld_k_s = 2'd0;
        end
        op_a_s = xr_r;
        op_b_s = yr_r;
        case (ld_k_s)
            2'd0: begin op_a_s = xr_r; op_b_s = yr_r; end
            2'd1: begin op_a_s = xi_r; op_b_s = yi_r; end
            2'd2: begin op_a_s = xr_r; op_b_s = yi_r; end
            2'd3: begin op_a_s = xi_r; op_b_s = yr_r; end
            default: begin op_a_s = xr_r; op_b_s = yr_r; end
        endcase
    end

    // Multiplier partial product and accumulator add/subtract
    always_comb begin
        partial_s = {PW{1'b0}};
        if (mplier_r[0]) begin
            partial_s = mcand_r;
        end else begin
            partial_s = {PW{1'b0}};
        end
        prod_ext_s = {{GUARD{prod_r[PW-1]}}, prod_r};
        acc_sub_s  = (k_r == 2'd1);
        acc_a_s    = res_re_r;
        if (k_r[1]) begin
            acc_a_s = res_im_r;
        end else begin
            acc_a_s = res_re_r;
        end
        acc_sum_s = {RW{1'b0}};
        if (acc_sub_s) begin
            acc_sum_s = acc_a_s - prod_ext_s;
        end else begin
            acc_sum_s = acc_a_s + prod_ext_s;
        end
        acc_ovf_s = acc_overflow(acc_a_s, prod_ext_s, acc_sum_s, acc_sub_s);
    end

    // Operand capture, multiplier stepping and result accumulation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xr_r     <= {W{1'b0}};
            xi_r     <= {W{1'b0}};
            yr_r     <= {W{1'b0}};
            yi_r     <= {W{1'b0}};
            accum_r  <= 1'b0;
            k_r      <= 2'd0;
            mcand_r  <= {PW{1'b0}};
            mplier_r <= {W{1'b0}};
            prod_r   <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            res_re_r <= {RW{1'b0}};
            res_im_r <= {RW{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                xr_r    <= x_re;
                xi_r    <= x_im;
                yr_r    <= y_re;
                yi_r    <= y_im;
                accum_r <= accum;
            end
            case (state_r)
                ST_IDLE: begin
                    if (clear) begin
                        res_re_r <= {RW{1'b0}};
                        res_im_r <= {RW{1'b0}};
                        ovf_r    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    k_r      <= 2'd0;
                    mcand_r  <= {{W{op_a_s[W-1]}}, op_a_s};
                    mplier_r <= op_b_s;
                    prod_r   <= {PW{1'b0}};
                    cnt_r    <= {CW{1'b0}};
                    if (!accum_r) begin
                        res_re_r <= {RW{1'b0}};
                        res_im_r <= {RW{1'b0}};
                        ovf_r    <= 1'b0;
                    end
                end
                ST_MUL: begin
                    // Multiplier MSB carries negative weight in two's complement
                    if (cnt_r == CNT_LAST) begin
                        prod_r <= prod_r - partial_s;
                    end else begin
                        prod_r <= prod_r + partial_s;
                    end
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
                ST_ACC: begin
                    if (k_r[1]) begin
                        res_im_r <= acc_sum_s;
                    end else begin
                        res_re_r <= acc_sum_s;
                    end
                    ovf_r <= ovf_r | acc_ovf_s;
                    if (k_r != 2'd3) begin
                        k_r      <= ld_k_s;
                        mcand_r  <= {{W{op_a_s[W-1]}}, op_a_s};
                        mplier_r <= op_b_s;
                        prod_r   <= {PW{1'b0}};
                        cnt_r    <= {CW{1'b0}};
                    end
                end
                ST_DONE: begin
                    k_r <= k_r;
                end
                default: begin
                    k_r <= 2'd0;
                end
            endcase
        end
    end

    // Registered status outputs decoded from the upcoming state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign res_re = res_re_r;
    assign res_im = res_im_r;
    assign ovf    = ovf_r;

endmodule

// File: tb/tb_complex_mac_seq.sv
// Randomized scoreboard bench for complex_mac_seq against an integer-arithmetic model.
module tb_complex_mac_seq;

    localparam int W     = 8;
    localparam int GUARD = 4;
    localparam int RW    = 2*W + GUARD;
    localparam longint MAXV = (longint'(1) <<< (RW-1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (RW-1));
    localparam longint MASK = (longint'(1) <<< RW) - 1;
    localparam int LAT   = 4*W + 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, accum = 1'b0, clear = 1'b0;
    logic signed [W-1:0] x_re = '0, x_im = '0, y_re = '0, y_im = '0;
    logic busy, done, ovf;
    logic signed [RW-1:0] res_re, res_im;

    complex_mac_seq #(.W(W), .GUARD(GUARD)) dut (
        .clk(clk), .rst(rst), .start(start), .accum(accum), .clear(clear),
        .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im),
        .busy(busy), .done(done), .res_re(res_re), .res_im(res_im), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint re;
        longint im;
        bit     ovf;
        longint cyc;
    } exp_t;

    exp_t   exp_q[$];
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;
    longint m_re = 0, m_im = 0;
    bit     m_ovf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic longint wrap_rw(input longint v);
        longint m;
        m = v & MASK;
        if (m > MAXV) m = m - (MASK + 1);
        return m;
    endfunction

    function automatic longint add_chk(input longint cur, input longint p);
        longint e;
        e = cur + p;
        if (e > MAXV || e < MINV) m_ovf = 1'b1;
        return wrap_rw(e);
    endfunction

    // Reference: full-precision complex products folded in with RW-bit wrap
    task automatic model_apply(input bit acc, input logic signed [W-1:0] a, b, c, d);
        longint ar, ai, br, bi;
        ar = longint'(a); ai = longint'(b); br = longint'(c); bi = longint'(d);
        if (!acc) begin
            m_re = 0; m_im = 0; m_ovf = 1'b0;
        end
        m_re = add_chk(m_re, ar * br);
        m_re = add_chk(m_re, -(ai * bi));
        m_im = add_chk(m_im, ar * bi);
        m_im = add_chk(m_im, ai * br);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("res_re", longint'(res_re), e.re);
                check("res_im", longint'(res_im), e.im);
                check("ovf", longint'(ovf), longint'(e.ovf));
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle(input bit chaos);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (!busy) begin
                ok = 1'b1;
            end else begin
                if (chaos) begin
                    x_re  = $urandom; x_im = $urandom; y_re = $urandom; y_im = $urandom;
                    accum = $urandom;
                    start = ($urandom_range(0, 2) == 0) && !done;
                    clear = ($urandom_range(0, 3) == 0) && !done;
                end
                @(negedge clk);
            end
        end
        check("busy_timeout", longint'(ok), 1);
        start = 1'b0;
        clear = 1'b0;
    endtask

    // Caller sits just after a negedge; the next rising edge accepts
    task automatic run_op(input bit acc, input logic signed [W-1:0] a, b, c, d, input bit chaos);
        exp_t e;
        start = 1'b1; clear = 1'b0; accum = acc;
        x_re = a; x_im = b; y_re = c; y_im = d;
        model_apply(acc, a, b, c, d);
        e.re = m_re; e.im = m_im; e.ovf = m_ovf; e.cyc = cyc + 1 + LAT;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_idle(chaos);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_res_re"}, longint'(res_re), 0);
        check({tag, "_res_im"}, longint'(res_im), 0);
        check({tag, "_ovf"}, longint'(ovf), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        run_op(1'b0, 8'sd3, 8'sd4, 8'sd5, -8'sd2, 1'b0);

        run_op(1'b0, -8'sd128, -8'sd128, -8'sd128, -8'sd128, 1'b0);
        for (int i = 0; i < 16; i++) begin
            run_op(1'b1, -8'sd128, -8'sd128, -8'sd128, -8'sd128, 1'b0);
        end
        run_op(1'b0, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0);

        run_op(1'b0, 8'sd100, -8'sd77, 8'sd31, 8'sd9, 1'b1);
        run_op(1'b1, -8'sd5, 8'sd127, -8'sd128, 8'sd64, 1'b1);

        start = 1'b1; clear = 1'b1;
        x_re = 8'sd7; x_im = 8'sd7; y_re = 8'sd7; y_im = 8'sd7;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        m_re = 0; m_im = 0; m_ovf = 1'b0;
        check_zero("clear_start");
        @(negedge clk);
        check("clear_start_busy_later", longint'(busy), 0);

        run_op(1'b0, 8'sd11, -8'sd13, 8'sd17, 8'sd19, 1'b0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_re = 0; m_im = 0; m_ovf = 1'b0;
        check_zero("clear");

        for (int i = 0; i < 20; i++) begin
            run_op(1'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                   1'($urandom_range(0, 1)));
        end

        start = 1'b1; accum = 1'b0;
        x_re = 8'sd50; x_im = 8'sd60; y_re = -8'sd70; y_im = 8'sd80;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_zero("async_reset");
        exp_q.delete();
        m_re = 0; m_im = 0; m_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op(1'b0, 8'sd3, 8'sd4, 8'sd5, -8'sd2, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_drained", longint'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
